sdes_stream_core: RTL
=====================

# sdes_stream_core

Sequential, handshaked S-DES engine: derives K1/K2 from a 10-bit key, encrypts or decrypts 8-bit blocks one fk round per clock, and supports ECB or CBC chaining with a loadable IV. It supersedes the purely combinational encrypt path. It sits between a byte source and a byte sink with valid/ready flow control on both sides, and reuses the existing IP, fk, SW and IPinv permutation/round logic.

## Interface
- CBC_EN, 1: 1 instantiates the chaining register and honours `cbc`; 0 ties `cbc` low internally and removes the chaining logic.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_load  input  1  pulse; captures `key`, `decrypt` and `cbc`, then runs the key schedule.
- key  input  [0:9]  10-bit S-DES key; bit 0 is the MSB.
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on `key_load`.
- cbc  input  1  0 = ECB, 1 = CBC; sampled on `key_load`.
- iv_load  input  1  pulse; captures `iv` into the chaining register.
- iv  input  [0:7]  initialisation vector.
- key_ready  output  1  subkeys valid and engine usable.
- in_valid  input  1  input block offered.
- in_ready  output  1  engine accepts a block this cycle.
- in_data  input  [0:7]  plaintext or ciphertext block.
- out_valid  output  1  result held on `out_data`.
- out_ready  input  1  sink accepts the result.
- out_data  output  [0:7]  result block.

## Operation
- Bit order: index 0 is the MSB. Permutation lists below are 1-based source positions.
- Key schedule:
  - P10 = 3 5 2 7 4 10 1 9 8 6.
  - Split the result into 5-bit halves.
  - Apply LS-1 to each half, then P8 = 6 3 7 4 8 5 10 9 gives K1.
  - Apply a further LS-2 to each half, then P8 gives K2.
  - For decryption, the round-1 key is K2 and the round-2 key is K1.
- Block path: IP, then fk(round-1 key), then SW, then fk(round-2 key), then IP⁻¹.
  - IP = 2 6 3 1 4 8 5 7.
  - EP = 4 1 2 3 2 3 4 1.
  - P4 = 2 4 3 1.
  - S0 and S1 are the standard S-DES boxes, identical to the existing fk.
- CBC encrypt: the engine input is `in_data` XOR chain. After the block, chain is set to `out_data`.
- CBC decrypt: `out_data` is the engine result XOR chain. After the block, chain is set to `in_data`.
- ECB: chain is unused and unchanged.
- State machine:
  - NOKEY (reset): `key_ready`=0, `in_ready`=0. `key_load` goes to KEYGEN.
  - KEYGEN: one cycle; registers K1 and K2, then goes to IDLE.
  - IDLE: `key_ready`=1, `in_ready`=1. `in_valid` goes to R1 and latches the IP'd (and pre-XOR'd) block.
  - R1: apply fk(round-1 key) and SW, then go to R2.
  - R2: apply fk(round-2 key), IP⁻¹ and the CBC output XOR, register `out_data`, then go to HOLD.
  - HOLD: `out_valid`=1. `out_ready` updates chain and goes to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap: at most one block is in flight.
- `key_load` in any state aborts any in-flight block, drops `out_valid`, and goes to KEYGEN. The chaining register is not cleared.
- `iv_load` takes effect only in NOKEY or IDLE; it is ignored otherwise.
  - If `iv_load` and `in_valid` coincide in IDLE, the new IV is applied to that block.
  - If `key_load` and `iv_load` coincide, both are captured.
- Reset values: `key_ready`=0, `in_ready`=0, `out_valid`=0, `out_data`=8'h00. K1, K2 and chain are 0. Mode is ECB encrypt.

## Timing
- `key_load` at cycle t gives `key_ready`=1 at t+2.
- Accept at cycle t (`in_valid` & `in_ready`) gives `out_valid`=1 from t+3, held stable until `out_ready`.
- `out_data` and `out_valid` are registered, with no combinational path from the inputs.
- Back-to-back throughput is one block per 4 cycles when `out_ready` is held high:
  - HOLD completes at t+3.
  - IDLE at t+4 accepts the next block.
- Asserting `rst` mid-block clears everything immediately. The block is lost and re-keying is required.

## Test plan
- Key schedule: key=1010000010, `key_load` → after 2 cycles K1=10100100, K2=01000011, `key_ready`=1.
- ECB encrypt: same key, `in_data`=10010111 → `out_data`=00111000 with `out_valid` at accept+3; with `decrypt`=1 re-keyed, 00111000 → 10010111.
- CBC round trip: IV=01010101, encrypt a 4-byte sequence, reload the IV, decrypt with the same key → original bytes recovered; outputs match a golden model.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_data` stable, `in_ready`=0 throughout, no block dropped or duplicated.
- Abort: `key_load` during R2 → `out_valid` never rises for that block, `key_ready` deasserts for one cycle, then the next block is encrypted with the new key.
- Reset mid-block and before key: assert `rst` in HOLD → all outputs return to reset values; `in_valid` before any `key_load` → `in_ready` stays 0.

Source files
------------

// File: rtl/sdes_stream_core.sv
// Handshaked S-DES engine: key schedule, one fk round per clock, optional
// CBC chaining with a loadable IV. At most one block is in flight.
module sdes_stream_core #(
   parameter bit CBC_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_load,
   input  logic [0:9] key,
   input  logic       decrypt,
   input  logic       cbc,
   input  logic       iv_load,
   input  logic [0:7] iv,
   output logic       key_ready,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [0:7] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [0:7] out_data
);

   typedef enum logic [2:0] {NOKEY, KEYGEN, IDLE, R1, R2, HOLD} state_t;

   // S-box rows packed MSB-first: row r occupies bits [31-8r -: 8], column c within a row at [7-2c -: 2]
   localparam logic [31:0] S0_TAB = {2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                     2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
   localparam logic [31:0] S1_TAB = {2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                     2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

   function automatic logic [1:0] sbox(input logic [31:0] tab, input logic [0:3] x);
      logic [31:0] row_sel;
      logic [7:0]  col_sel;
      row_sel = tab << {x[0], x[3], 3'b000};
      col_sel = row_sel[31:24] << {x[1], x[2], 1'b0};
      return col_sel[7:6];
   endfunction

   function automatic logic [0:7] fk(input logic [0:7] b, input logic [0:7] k);
      logic [0:7] e;
      logic [0:3] s;
      logic [0:3] p;
      e = {b[7], b[4], b[5], b[6], b[5], b[6], b[7], b[4]} ^ k;
      s = {sbox(S0_TAB, e[0:3]), sbox(S1_TAB, e[4:7])};
      p = {s[1], s[3], s[2], s[0]};
      return {b[0:3] ^ p, b[4:7]};
   endfunction

   function automatic logic [0:7] ip(input logic [0:7] b);
      return {b[1], b[5], b[2], b[0], b[3], b[7], b[4], b[6]};
   endfunction

   function automatic logic [0:7] ip_inv(input logic [0:7] b);
      return {b[3], b[0], b[2], b[4], b[6], b[1], b[7], b[5]};
   endfunction

   function automatic logic [0:7] sw(input logic [0:7] b);
      return {b[4:7], b[0:3]};
   endfunction

   function automatic logic [0:7] p8(input logic [0:9] h);
      return {h[5], h[2], h[6], h[3], h[7], h[4], h[9], h[8]};
   endfunction

   state_t     state_q, state_d;
   logic [0:9] key_q, key_d;
   logic       dec_q, dec_d;
   logic       cbc_q, cbc_d;
   logic [0:7] k1_q, k1_d;
   logic [0:7] k2_q, k2_d;
   logic [0:7] chain_q, chain_d;
   logic [0:7] data_q, data_d;
   logic [0:7] in_q, in_d;
   logic [0:7] out_q, out_d;

   logic       cbc_act;
   logic [0:7] rk1, rk2, chain_in, pre_x, post_x;
   logic [0:9] p10k, ls1k, ls3k;

   assign p10k = {key_q[2], key_q[4], key_q[1], key_q[6], key_q[3],
                  key_q[9], key_q[0], key_q[8], key_q[7], key_q[5]};
   assign ls1k = {p10k[1:4], p10k[0], p10k[6:9], p10k[5]};
   assign ls3k = {ls1k[2:4], ls1k[0:1], ls1k[7:9], ls1k[5:6]};

   assign cbc_act = CBC_EN && cbc_q;
   assign rk1     = dec_q ? k2_q : k1_q;
   assign rk2     = dec_q ? k1_q : k2_q;
   // An IV loaded in the same cycle as the accept chains into that very block.
   assign chain_in = (iv_load && state_q == IDLE) ? iv : chain_q;
   assign pre_x    = (cbc_act && !dec_q) ? chain_in : '0;
   assign post_x   = (cbc_act && dec_q) ? chain_q : '0;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      dec_d   = dec_q;
      cbc_d   = cbc_q;
      k1_d    = k1_q;
      k2_d    = k2_q;
      chain_d = chain_q;
      data_d  = data_q;
      in_d    = in_q;
      out_d   = out_q;

      if (key_load) begin
         state_d = KEYGEN;
         key_d   = key;
         dec_d   = decrypt;
         cbc_d   = cbc;
      end else begin
         case (state_q)
            NOKEY: state_d = NOKEY;
            KEYGEN: begin
               k1_d    = p8(ls1k);
               k2_d    = p8(ls3k);
               state_d = IDLE;
            end
            IDLE: if (in_valid) begin
               data_d  = ip(in_data ^ pre_x);
               in_d    = in_data;
               state_d = R1;
            end
            R1: begin
               data_d  = sw(fk(data_q, rk1));
               state_d = R2;
            end
            R2: begin
               out_d   = ip_inv(fk(data_q, rk2)) ^ post_x;
               state_d = HOLD;
            end
            HOLD: if (out_ready) begin
               if (cbc_act) chain_d = dec_q ? in_q : out_q;
               state_d = IDLE;
            end
            default: state_d = NOKEY;
         endcase
      end

      if (iv_load && (key_load || state_q == NOKEY || state_q == IDLE)) chain_d = iv;

      key_ready = (state_q == IDLE) || (state_q == R1) || (state_q == R2) || (state_q == HOLD);
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == HOLD);
      out_data  = out_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= NOKEY;
         key_q   <= '0;
         dec_q   <= 1'b0;
         cbc_q   <= 1'b0;
         k1_q    <= '0;
         k2_q    <= '0;
         chain_q <= '0;
         data_q  <= '0;
         in_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         dec_q   <= dec_d;
         cbc_q   <= cbc_d;
         k1_q    <= k1_d;
         k2_q    <= k2_d;
         chain_q <= chain_d;
         data_q  <= data_d;
         in_q    <= in_d;
         out_q   <= out_d;
      end
   end

endmodule
